// File: rtl/gate_tt_pkg.sv
// Shared constants for the gate truth-table checker: FSM state encodings and
// expected truth tables of the common 2-input gates.
package gate_tt_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    localparam int unsigned SETTLE_W = 8;

    // Bit i is the expected gate output for input vector i (bit 0 = a, bit 1 = b).
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_XNOR2 = 4'b1001;

endpackage

// File: rtl/gate_truth_table_checker.sv
// Sweeps every input vector of an N-input combinational gate, samples its output
// after a settle interval and scores it against an expected truth table.
module gate_truth_table_checker
    import gate_tt_pkg::*;
#(
    parameter int unsigned                  N_INPUTS      = 2,
    parameter logic [(2**N_INPUTS)-1:0]     EXPECTED_TT   = 4'b1000,
    parameter int unsigned                  SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_INPUTS-1:0] vec_out,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic                first_fail_valid,
    output logic [N_INPUTS-1:0] first_fail_vec,
    output logic                sample_strobe,
    output logic                sample_y
);

    localparam int unsigned ERR_W = N_INPUTS + 1;
    localparam logic [N_INPUTS-1:0] LAST_VEC = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [STATE_W-1:0]  state,        state_n;
    logic [N_INPUTS-1:0] idx,          idx_n;
    logic [SETTLE_W-1:0] settle_cnt,   settle_cnt_n;
    logic [N_INPUTS-1:0] vec_out_n;
    logic                busy_n, done_n, pass_n;
    logic [ERR_W-1:0]    err_count_n;
    logic                first_fail_valid_n;
    logic [N_INPUTS-1:0] first_fail_vec_n;
    logic                sample_strobe_n, sample_y_n;
    logic                mismatch;
    logic [ERR_W-1:0]    err_inc;

    assign mismatch = (dut_y != EXPECTED_TT[idx]);
    assign err_inc  = err_count + ERR_W'(mismatch);

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_n            = state;
        idx_n              = idx;
        settle_cnt_n       = settle_cnt;
        vec_out_n          = vec_out;
        busy_n             = busy;
        done_n             = done;
        pass_n             = pass;
        err_count_n        = err_count;
        first_fail_valid_n = first_fail_valid;
        first_fail_vec_n   = first_fail_vec;
        sample_strobe_n    = 1'b0;
        sample_y_n         = sample_y;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n            = ST_RUN;
                    busy_n             = 1'b1;
                    done_n             = 1'b0;
                    pass_n             = 1'b0;
                    err_count_n        = '0;
                    first_fail_valid_n = 1'b0;
                    first_fail_vec_n   = '0;
                    idx_n              = '0;
                    vec_out_n          = '0;
                    settle_cnt_n       = SETTLE_RELOAD;
                end
            end
            ST_RUN: begin
                if (settle_cnt != '0) begin
                    settle_cnt_n = settle_cnt - SETTLE_W'(1);
                end else begin
                    sample_strobe_n = 1'b1;
                    sample_y_n      = dut_y;
                    err_count_n     = err_inc;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid_n = 1'b1;
                        first_fail_vec_n   = idx;
                    end
                    if (idx == LAST_VEC) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        // Uses the updated count so a final-vector mismatch fails the sweep.
                        pass_n  = (err_inc == '0);
                    end else begin
                        idx_n        = idx + N_INPUTS'(1);
                        vec_out_n    = idx + N_INPUTS'(1);
                        settle_cnt_n = SETTLE_RELOAD;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            idx              <= '0;
            settle_cnt       <= '0;
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            sample_strobe    <= 1'b0;
            sample_y         <= 1'b0;
        end else begin
            state            <= state_n;
            idx              <= idx_n;
            settle_cnt       <= settle_cnt_n;
            vec_out          <= vec_out_n;
            busy             <= busy_n;
            done             <= done_n;
            pass             <= pass_n;
            err_count        <= err_count_n;
            first_fail_valid <= first_fail_valid_n;
            first_fail_vec   <= first_fail_vec_n;
            sample_strobe    <= sample_strobe_n;
            sample_y         <= sample_y_n;
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: four checker instances each scoring a 2-input AND gate against
// different truth tables and settle intervals.
module tb_gate_truth_table_checker;
    import gate_tt_pkg::*;

    logic clk;
    logic rst_n;
    logic start;

    int n_checks;
    int n_errors;

    // Per-instance signal bundle: a = AND/default, o = OR table, s = settle 3, l = all-zero table
    logic [1:0] a_vec, o_vec, s_vec, l_vec;
    logic       a_y, o_y, s_y, l_y;
    logic       a_busy, o_busy, s_busy, l_busy;
    logic       a_done, o_done, s_done, l_done;
    logic       a_pass, o_pass, s_pass, l_pass;
    logic [2:0] a_err, o_err, s_err, l_err;
    logic       a_ffv, o_ffv, s_ffv, l_ffv;
    logic [1:0] a_ffvec, o_ffvec, s_ffvec, l_ffvec;
    logic       a_stb, o_stb, s_stb, l_stb;
    logic       a_sy, o_sy, s_sy, l_sy;

    // The gate under test: a real 2-input AND per instance.
    assign a_y = a_vec[0] & a_vec[1];
    assign o_y = o_vec[0] & o_vec[1];
    assign s_y = s_vec[0] & s_vec[1];
    assign l_y = l_vec[0] & l_vec[1];

    gate_truth_table_checker #(.N_INPUTS(2), .EXPECTED_TT(TT_AND2), .SETTLE_CYCLES(1)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(a_vec), .dut_y(a_y),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec),
        .sample_strobe(a_stb), .sample_y(a_sy));

    gate_truth_table_checker #(.N_INPUTS(2), .EXPECTED_TT(TT_OR2), .SETTLE_CYCLES(1)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(o_vec), .dut_y(o_y),
        .busy(o_busy), .done(o_done), .pass(o_pass), .err_count(o_err),
        .first_fail_valid(o_ffv), .first_fail_vec(o_ffvec),
        .sample_strobe(o_stb), .sample_y(o_sy));

    gate_truth_table_checker #(.N_INPUTS(2), .EXPECTED_TT(TT_AND2), .SETTLE_CYCLES(3)) u_settle3 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(s_vec), .dut_y(s_y),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .first_fail_valid(s_ffv), .first_fail_vec(s_ffvec),
        .sample_strobe(s_stb), .sample_y(s_sy));

    gate_truth_table_checker #(.N_INPUTS(2), .EXPECTED_TT(4'b0000), .SETTLE_CYCLES(1)) u_last (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_out(l_vec), .dut_y(l_y),
        .busy(l_busy), .done(l_done), .pass(l_pass), .err_count(l_err),
        .first_fail_valid(l_ffv), .first_fail_vec(l_ffvec),
        .sample_strobe(l_stb), .sample_y(l_sy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int strobes;
    int done_cycles;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        #12;
        check("rst_vec",   a_vec,   0);
        check("rst_busy",  a_busy,  0);
        check("rst_done",  a_done,  0);
        check("rst_err",   a_err,   0);
        check("rst_stb",   a_stb,   0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", a_busy, 0);

        // Sweep 1: all instances start at e0.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a_vec_e0",  a_vec,  0);
        check("a_busy_e0", a_busy, 1);
        check("a_stb_e0",  a_stb,  0);
        strobes = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 3) begin
                check($sformatf("a_vec_%0d", k), a_vec, k);
                check($sformatf("a_stb_%0d", k), a_stb, 1);
                check($sformatf("a_sy_%0d", k),  a_sy,  0);
                check($sformatf("a_done_%0d", k), a_done, 0);
            end
            if (k == 3) begin
                check("l_err_pre", l_err,  0);
                check("l_done_pre", l_done, 0);
            end
            if (k == 4) begin
                check("a_done",  a_done,  1);
                check("a_busy",  a_busy,  0);
                check("a_pass",  a_pass,  1);
                check("a_err",   a_err,   0);
                check("a_ffv",   a_ffv,   0);
                check("a_sy_4",  a_sy,    1);
                check("a_vec_4", a_vec,   3);
                check("o_done",  o_done,  1);
                check("o_pass",  o_pass,  0);
                check("o_err",   o_err,   2);
                check("o_ffv",   o_ffv,   1);
                check("o_ffvec", o_ffvec, 1);
                check("l_done",  l_done,  1);
                check("l_pass",  l_pass,  0);
                check("l_err",   l_err,   1);
                check("l_ffvec", l_ffvec, 3);
            end
            if (k == 5) begin
                check("a_done_hold", a_done, 1);
                check("a_stb_5",     a_stb,  0);
            end
            if (s_stb) strobes++;
            check($sformatf("s_stb_%0d", k),  s_stb,  (k % 3 == 0) ? 1 : 0);
            check($sformatf("s_vec_%0d", k),  s_vec,  (k < 12) ? k / 3 : 3);
            check($sformatf("s_done_%0d", k), s_done, (k == 12) ? 1 : 0);
        end
        check("s_strobes", strobes, 4);
        check("s_pass",    s_pass,  1);

        // Sweep 2: start during busy is ignored, then reset mid restarted sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_vec2",  a_vec,  2);
        check("ign_busy",  a_busy, 1);
        tick();
        check("ign_vec3",  a_vec,  3);
        tick();
        check("ign_done",  a_done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_busy",   a_busy, 1);
        check("rs_done",   a_done, 0);
        check("rs_o_err",  o_err,  0);
        tick();
        check("rs_vec1",   a_vec,  1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_vec",    a_vec,  0);
        check("ar_busy",   a_busy, 0);
        check("ar_stb",    a_stb,  0);
        check("ar_sy",     a_sy,   0);
        check("ar_o_err",  o_err,  0);
        check("ar_o_ffv",  o_ffv,  0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_busy", a_busy, 0);
        check("post_done", a_done, 0);
        check("post_vec",  a_vec,  0);

        // Sweep 3: start held high; back-to-back sweeps with one DONE cycle each.
        start = 1'b1;
        done_cycles = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (a_done) done_cycles++;
            if (k == 4) check("bb_o_err4", o_err, 2);
            if (k == 5) begin
                check("bb_o_err5", o_err,  0);
                check("bb_done5",  a_done, 0);
            end
            if (k == 9) check("bb_done9", a_done, 1);
        end
        start = 1'b0;
        check("bb_done_cycles", done_cycles, 2);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
